cronometru_traseu: RTL

Run-time stopwatch for the line-follower car: counts elapsed seconds of a run as two BCD digits, 00–99. It sits directly upstream of the multiplexed 7-segment display driver. Its `cifra_zeci`/`cifra_unitati` outputs feed the display's digit inputs, and its `stop` output drives the display's stop input. Start and stop requests come from the car's control logic (push-button start, end-of-track or line-lost detection).

---
 rtl/cronometru_traseu_if.sv | 20 ++
 rtl/cronometru_traseu.sv | 107 ++++++++++
 2 files changed

// File: rtl/cronometru_traseu_if.sv
// Bus between the car's control logic and the run-time stopwatch:
// start/stop requests in, BCD digits and run-state flags out.
interface cronometru_traseu_if;
  logic       start;
  logic       oprire;
  logic [3:0] cifra_zeci;
  logic [3:0] cifra_unitati;
  logic       stop;
  logic       activ;

  modport master (
    output start, oprire,
    input  cifra_zeci, cifra_unitati, stop, activ
  );

  modport slave (
    input  start, oprire,
    output cifra_zeci, cifra_unitati, stop, activ
  );
endinterface

// File: rtl/cronometru_traseu.sv
// Run-time stopwatch: two BCD digits 00-99 advanced once every DIVIZOR cycles.
// Optional macro CRONOMETRU_SATURARE_EN: freeze at 99 and stop instead of wrapping to 00.
module cronometru_traseu #(
  parameter int unsigned DIVIZOR = 50000000
) (
  input logic           clock,
  input logic           reset,
  cronometru_traseu_if.slave bus
);

  localparam int unsigned PW = (DIVIZOR > 1) ? $clog2(DIVIZOR) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIVIZOR - 1);

  typedef enum logic [1:0] {
    ASTEPTARE = 2'd0,
    NUMARARE  = 2'd1,
    OPRIT     = 2'd2
  } stare_t;

  stare_t        stare_reg, stare_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic [3:0]    zeci_reg, zeci_next;
  logic [3:0]    unit_reg, unit_next;
  logic          stop_reg, stop_next;
  logic          activ_reg, activ_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      stare_reg <= ASTEPTARE;
      pre_reg   <= '0;
      zeci_reg  <= 4'd0;
      unit_reg  <= 4'd0;
      stop_reg  <= 1'b0;
      activ_reg <= 1'b0;
    end else begin
      stare_reg <= stare_next;
      pre_reg   <= pre_next;
      zeci_reg  <= zeci_next;
      unit_reg  <= unit_next;
      stop_reg  <= stop_next;
      activ_reg <= activ_next;
    end
  end

  always_comb begin
    stare_next = stare_reg;
    pre_next   = pre_reg;
    zeci_next  = zeci_reg;
    unit_next  = unit_reg;

    case (stare_reg)
      ASTEPTARE: begin
        if (bus.start) begin
          stare_next = NUMARARE;
          pre_next   = '0;
        end
      end

      NUMARARE: begin
        // A stop request wins over a coincident tick: the digits freeze unchanged.
        if (bus.oprire) begin
          stare_next = OPRIT;
        end else if (pre_reg == PRE_MAX) begin
          pre_next = '0;
          if (unit_reg < 4'd9) begin
            unit_next = unit_reg + 4'd1;
          end else if (zeci_reg < 4'd9) begin
            unit_next = 4'd0;
            zeci_next = zeci_reg + 4'd1;
          end else begin
`ifdef CRONOMETRU_SATURARE_EN
            stare_next = OPRIT;
`else
            unit_next = 4'd0;
            zeci_next = 4'd0;
`endif
          end
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end

      OPRIT: begin
        if (bus.start) begin
          stare_next = NUMARARE;
          pre_next   = '0;
          zeci_next  = 4'd0;
          unit_next  = 4'd0;
        end
      end

      default: begin
        stare_next = ASTEPTARE;
      end
    endcase

    // Flags are registered alongside the state so they track it with no input-to-output path.
    stop_next  = (stare_next == OPRIT);
    activ_next = (stare_next == NUMARARE);
  end

  assign bus.cifra_zeci    = zeci_reg;
  assign bus.cifra_unitati = unit_reg;
  assign bus.stop          = stop_reg;
  assign bus.activ         = activ_reg;

endmodule
